// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding memory read at a time, feeding a
// DEPTH-entry FIFO of {instr, pc+4}; redirects flush the queue and retarget fetch.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_plus4
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] { IDLE, REQ, DROP } state_t;

    state_t           state, state_next;
    logic [31:0]      fetch_pc, fetch_pc_next, drop_addr;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      pc4_q   [DEPTH];
    logic             push, pop;

    assign out_valid    = (count != '0);
    assign out_instr    = out_valid ? instr_q[rd_ptr] : 32'h0;
    assign out_pc_plus4 = out_valid ? pc4_q[rd_ptr]   : 32'h0;

    assign pop  = out_valid && !stall && !redirect;
    assign push = (state == REQ) && mem_ready && !redirect;

    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Decisions use the post-edge count so issue restarts as soon as a slot frees.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        mem_req       = 1'b0;
        mem_addr      = fetch_pc;
        case (state)
            IDLE: begin
                if (!redirect && (count_next < FULL)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (redirect) begin
                    state_next = mem_ready ? IDLE : DROP;
                end else if (mem_ready) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    state_next    = (count_next < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                mem_req  = 1'b1;
                mem_addr = drop_addr;
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect) begin
            fetch_pc_next = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            count    <= count_next;
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage and the in-flight address of an abandoned request need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= mem_rdata;
            pc4_q[wr_ptr]   <= fetch_pc + 32'd4;
        end
        if ((state == REQ) && redirect && !mem_ready) begin
            drop_addr <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory responder + sequential-stream reference model,
// scoreboard of expected queue entries checked by an independent monitor.
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk, reset, mem_req, mem_ready, stall, redirect, out_valid;
    logic [31:0] mem_addr, mem_rdata, redirect_pc, out_instr, out_pc_plus4;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
        .out_instr(out_instr), .out_pc_plus4(out_pc_plus4)
    );

    typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } entry_t;
    entry_t      sb[$];
    int          errors = 0, checks = 0;
    logic [31:0] exp_pc, req_addr, force_pc;
    bit          req_active, req_stale, force_redir, spur, found;
    int          wait_left, lat_mode, stall_mode, redir_pct, n_push;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] fmem(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: entered at negedge+1, drives inputs, updates the model at +4.
    task automatic step();
        if (mem_req) begin
            if (!req_active) begin
                req_active = 1'b1;
                req_addr   = mem_addr;
                req_stale  = 1'b0;
                wait_left  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                chk("req_addr", mem_addr, exp_pc);
            end else begin
                chk("addr_hold", mem_addr, req_addr);
            end
            mem_ready = (wait_left == 0);
            if (wait_left > 0) wait_left--;
            mem_rdata = mem_ready ? fmem(req_addr) : $urandom;
        end else begin
            if (req_active) begin
                chk("req_abandoned", 32'(mem_req), 32'd1);
                req_active = 1'b0;
            end
            mem_ready = spur && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
        if (stall_mode == 2) stall = 1'($urandom_range(0, 1));
        else                 stall = (stall_mode == 1);
        if (force_redir) begin
            redirect    = 1'b1;
            redirect_pc = force_pc;
            force_redir = 1'b0;
        end else begin
            redirect = ($urandom_range(0, 99) < redir_pct);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            else
                redirect_pc = $urandom & 32'h0000_FFFC;
        end
        #3;
        if (redirect) begin
            sb.delete();
            exp_pc = redirect_pc;
            if (req_active && mem_req && !mem_ready) req_stale = 1'b1;
        end else if (mem_req && mem_ready && !req_stale) begin
            sb.push_back('{instr: fmem(req_addr), pc4: req_addr + 32'd4});
            exp_pc = exp_pc + 32'd4;
            n_push++;
        end
        if (mem_req && mem_ready) req_active = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check_now);
        reset = 1'b0;
        mem_ready = 1'b0; redirect = 1'b0; stall = 1'b0; force_redir = 1'b0;
        sb.delete();
        exp_pc = RESET_PC; req_active = 1'b0; req_stale = 1'b0; n_push = 0;
        #1;
        if (check_now) begin
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", mem_addr, RESET_PC);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_instr", out_instr, 32'd0);
            chk("rst_out_pc4", out_pc_plus4, 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: compares the presented head against the scoreboard and retires it on dequeue.
    always begin
        @(negedge clk);
        #3;
        if (reset) begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("head_instr", out_instr, sb[0].instr);
                chk("head_pc4", out_pc_plus4, sb[0].pc4);
                if (out_valid && !stall && !redirect) void'(sb.pop_front());
            end else begin
                chk("nop_instr", out_instr, 32'd0);
                chk("nop_pc4", out_pc_plus4, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0; force_redir = 1'b0; force_pc = '0;
        exp_pc = RESET_PC; req_addr = '0; req_active = 1'b0; req_stale = 1'b0;
        wait_left = 0; n_push = 0; found = 1'b0;
        lat_mode = 0; stall_mode = 0; redir_pct = 0; spur = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc4", out_pc_plus4, 32'd0);
        reset = 1'b1;

        // Zero-wait streaming: addresses every cycle, outputs one behind.
        step();
        for (int k = 0; k < 8; k++) begin
            chk("seq_req", 32'(mem_req), 32'd1);
            chk("seq_addr", mem_addr, 32'(4 * k));
            if (k > 0) chk("seq_pc4", out_pc_plus4, 32'(4 * k));
            step();
        end

        // Stall held: fill to DEPTH, then drain and resume.
        do_reset(1'b0);
        stall_mode = 1;
        repeat (5) step();
        chk("full_req", 32'(mem_req), 32'd0);
        chk("full_pushes", 32'(n_push), 32'(DEPTH));
        chk("full_head", out_pc_plus4, 32'd4);
        repeat (3) step();
        chk("full_hold", 32'(mem_req), 32'd0);
        chk("full_pushes_hold", 32'(n_push), 32'(DEPTH));
        stall_mode = 0;
        step();
        chk("resume_req", 32'(mem_req), 32'd1);
        chk("resume_addr", mem_addr, 32'd16);
        chk("drain_head", out_pc_plus4, 32'd8);
        repeat (10) step();

        // Slow memory, redirect during the second wait cycle.
        do_reset(1'b0);
        lat_mode = 3;
        step();
        chk("lat_req", 32'(mem_req), 32'd1);
        chk("lat_addr", mem_addr, RESET_PC);
        step();
        force_redir = 1'b1; force_pc = 32'h100;
        step();
        chk("drop_req", 32'(mem_req), 32'd1);
        chk("drop_addr", mem_addr, RESET_PC);
        chk("drop_valid", 32'(out_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_req && !req_active) begin found = 1'b1; break; end
        end
        chk("redir_req_seen", 32'(found), 32'd1);
        chk("redir_req_addr", mem_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin found = 1'b1; break; end
            step();
        end
        chk("redir_out_seen", 32'(found), 32'd1);
        chk("redir_out_pc4", out_pc_plus4, 32'h104);
        chk("redir_out_instr", out_instr, fmem(32'h100));

        // Redirect coinciding with mem_ready and a dequeue.
        do_reset(1'b0);
        lat_mode = 0;
        repeat (2) step();
        chk("pre_valid", 32'(out_valid), 32'd1);
        chk("pre_req", 32'(mem_req), 32'd1);
        force_redir = 1'b1; force_pc = 32'h2000;
        step();
        chk("coll_valid", 32'(out_valid), 32'd0);
        chk("coll_req", 32'(mem_req), 32'd0);
        chk("coll_addr", mem_addr, 32'h2000);
        step();
        chk("coll_next_req", 32'(mem_req), 32'd1);
        chk("coll_next_addr", mem_addr, 32'h2000);

        // Address wrap at the top of the address space.
        stall_mode = 1;
        force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
        step();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_req && !req_active) begin found = 1'b1; break; end
        end
        chk("wrap_req_seen", 32'(found), 32'd1);
        chk("wrap_req_addr", mem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc4", out_pc_plus4, 32'd0);
        chk("wrap_next_addr", mem_addr, 32'd0);

        // Reset in the middle of a request with two entries queued.
        do_reset(1'b0);
        repeat (3) step();
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_addr", mem_addr, 32'd8);
        do_reset(1'b1);
        step();
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", mem_addr, RESET_PC);

        // Randomised traffic.
        lat_mode = -1; stall_mode = 2; redir_pct = 5; spur = 1'b1;
        repeat (3000) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port mem_req, output, 1 bit: instruction-memory read request.
REQ-006 The block SHALL have port mem_addr, output, 32 bits: read address, held stable while mem_req=1.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: read complete this cycle; may be high in the same cycle mem_req rises.
REQ-008 The block SHALL have port mem_rdata, input, 32 bits: instruction word, valid when mem_ready=1.
REQ-009 The block SHALL have port stall, input, 1 bit: the pipeline is not accepting an instruction (the PC-write/IF-write hazard hold).
REQ-010 The block SHALL have port redirect, input, 1 bit: taken branch, bne or jump resolved in ID.
REQ-011 The block SHALL have port redirect_pc, input, 32 bits: new fetch address, valid when redirect=1.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-013 The block SHALL have port out_instr, output, 32 bits: head instruction; 32'h0 (nop) when out_valid=0.
REQ-014 The block SHALL have port out_pc_plus4, output, 32 bits: address of the head instruction + 4; 0 when out_valid=0.

Function
REQ-015 The block SHALL hold a DEPTH-entry circular FIFO of {instr, pc_plus4}, read/write pointers that wrap modulo DEPTH, and a count in the range 0..DEPTH.
REQ-016 The block SHALL implement an FSM with states IDLE (no request outstanding), REQ (mem_req=1, mem_addr=fetch_pc) and DROP (mem_req=1, response to be discarded).
REQ-017 In IDLE, when count<DEPTH and redirect=0, the block SHALL move to REQ on the next edge.
REQ-018 In REQ with mem_ready=1 and redirect=0, the block SHALL push {mem_rdata, fetch_pc+4} and set fetch_pc to fetch_pc+4.
REQ-019 After the push in REQ-018, the block SHALL stay in REQ if the post-edge count is less than DEPTH, otherwise move to IDLE; this gives back-to-back issue with no bubble for a zero-wait memory.
REQ-020 Address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-021 A dequeue SHALL occur when out_valid=1, stall=0 and redirect=0; the head advances on the next edge.
REQ-022 A push and a dequeue in the same cycle SHALL leave count unchanged; a push is allowed when full if a dequeue occurs in the same cycle.
REQ-023 A redirect SHALL take priority over push and dequeue: count=0, pointers=0 and fetch_pc=redirect_pc on the next edge.
REQ-024 On redirect, the next state SHALL be:
  - from REQ without mem_ready: DROP;
  - from REQ with mem_ready: IDLE, with the data discarded;
  - from IDLE: IDLE;
  - from DROP without mem_ready: DROP, with fetch_pc updated.
REQ-025 In DROP, mem_addr SHALL hold the old address until mem_ready; that response SHALL be discarded and the FSM SHALL move to IDLE.
REQ-026 The block SHALL never have more than one request outstanding, and SHALL never push while in DROP.
REQ-027 The head entry SHALL drive out_instr and out_pc_plus4 combinationally, with latency from push edge to out_valid of one cycle.

Reset
REQ-028 While reset=0, asynchronously:
  - state=IDLE, count=0 and pointers=0;
  - fetch_pc=RESET_PC;
  - mem_req=0 and mem_addr=RESET_PC;
  - out_valid=0, out_instr=0 and out_pc_plus4=0.
REQ-029 Reset asserted mid-request SHALL abandon the request; a mem_ready arriving after reset release while in IDLE SHALL be ignored.
REQ-030 Queue storage contents SHALL NOT need reset; outputs SHALL be masked by out_valid.

Verification
REQ-031 Zero-wait memory (mem_ready=mem_req), stall=0, RESET_PC=0 -> mem_addr 0,4,8,... on consecutive cycles; out_pc_plus4 4,8,12,... one cycle behind.
REQ-032 stall held at 1 with zero-wait memory -> exactly 4 pushes, then mem_req=0 and count=4; releasing stall -> in-order drain and issue resumes the same cycle count drops below 4.
REQ-033 3-cycle memory latency with redirect to 32'h100 in the 2nd wait cycle -> state DROP, old data discarded, next request addr 32'h100, first output pc_plus4=32'h104.
REQ-034 redirect in the same cycle as mem_ready and a dequeue -> nothing pushed or dequeued, out_valid=0 next cycle, next mem_addr=redirect_pc.
REQ-035 reset asserted during REQ with count=2 -> all outputs at reset values immediately; after release, the first mem_addr equals RESET_PC.
REQ-036 Fetch at 32'hFFFF_FFFC -> pushed pc_plus4=0 and next mem_addr=0.
